// File: rtl/adder11_rr_scheduler.sv
// Round-robin shared 8-bit adder with a single-entry tagged result register.
// Define ADDER11_RR_STATS_EN to add saturating accept/stall counters.
module adder11_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_sum,
`ifdef ADDER11_RR_STATS_EN
    output logic [15:0]        stat_accepts,
    output logic [15:0]        stat_stalls,
`endif
    output logic [ID_W-1:0]    rsp_id
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
        $error("adder11_rr_scheduler: N_REQ out of range 2..8");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_bad_w
        $error("adder11_rr_scheduler: ID_W must equal clog2(N_REQ)");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    logic            can_accept;
    logic [7:0]      sum;

    function automatic logic [7:0] adder11(input logic [7:0] a,
                                           input logic [7:0] b);
        return a + b;
    endfunction

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) | (rsp_ready & rsp_valid);

    // Scan from ptr with wrap; first valid requester wins.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        win_id = '0;
        if (can_accept && !wb_rst_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    win_id = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign sum      = adder11(req_a[int'(win_id)*8 +: 8],
                              req_b[int'(win_id)*8 +: 8]);
    assign next_ptr = ID_W'((int'(win_id) + 1) % N_REQ);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= EMPTY;
            rsp_sum <= '0;
            rsp_id  <= '0;
            ptr     <= '0;
        end else begin
            if (found) begin
                state   <= FULL;
                rsp_sum <= sum;
                rsp_id  <= win_id;
                ptr     <= next_ptr;
            end else if (rsp_valid && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

`ifdef ADDER11_RR_STATS_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_accepts <= '0;
            stat_stalls  <= '0;
        end else begin
            if (found && stat_accepts != 16'hFFFF) begin
                stat_accepts <= stat_accepts + 16'd1;
            end
            if (rsp_valid && !rsp_ready && stat_stalls != 16'hFFFF) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule
